// File: rtl/muon_pkg.sv
// Shared definitions for the muon-lifetime TDC run controller:
// FSM state encoding, default timing constants and a saturating increment.
package muon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_TIMING  = 2'd2,
        ST_HOLDOFF = 2'd3
    } tdc_state_e;

    // 100 clk cycles per TDC count gives 1 us resolution at 100 MHz.
    localparam int unsigned CLK_DIV_DEFAULT        = 100;
    localparam int unsigned TIMEOUT_COUNT_DEFAULT  = 20000;
    localparam int unsigned HOLDOFF_CYCLES_DEFAULT = 1000;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    // Add one but stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] satInc(input logic [15:0] value);
        return (value == COUNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/tdc_tick_gen.sv
// Prescaler for the TDC: counts clk cycles while enabled and emits a
// one-cycle tick every DIV cycles. clear_i restarts the division phase.
module tdc_tick_gen #(
    parameter int unsigned DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_en_i,
    output logic tick_o
);

    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] pre_q;
    logic        wrap;

    assign wrap   = (pre_q == LAST);
    assign tick_o = count_en_i && wrap;

    // Phase counter: zeroed on reset or clear, wraps at DIV-1 while enabled.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            pre_q <= 16'd0;
        end else if (count_en_i) begin
            pre_q <= wrap ? 16'd0 : pre_q + 16'd1;
        end
    end

endmodule

// File: rtl/tdc_run_ctrl.sv
// Muon-decay run controller: arms on enable, measures start_hit -> stop_hit
// in TDC counts, then enforces a holdoff dead time before re-arming.
// Optional feature: define TDC_TIMEOUT_EN to abandon windows that reach
// TIMEOUT_COUNT; without it the TDC count saturates and the window stays open.
module tdc_run_ctrl
    import muon_pkg::*;
#(
    parameter int unsigned CLK_DIV        = CLK_DIV_DEFAULT,
    parameter int unsigned TIMEOUT_COUNT  = TIMEOUT_COUNT_DEFAULT,
    parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        start_hit,
    input  logic        stop_hit,
    input  logic        clear,
    output logic [15:0] result,
    output logic        result_valid,
    output logic [15:0] event_count,
    output logic        timeout_pulse,
    output logic        busy
);

    localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_CYCLES - 1);

    // Refuse to elaborate with timing parameters outside their usable range.
    if (CLK_DIV < 2 || CLK_DIV > 65535 ||
        TIMEOUT_COUNT < 1 || TIMEOUT_COUNT > 65535 ||
        HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 65535) begin : gBadParams
        $error("tdc_run_ctrl: timing parameter out of range");
    end

    tdc_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] result_q, result_d;
    logic [15:0] events_q, events_d;
    logic        valid_q, valid_d;
    logic        timeout_q, timeout_d;
    logic        tick;
    logic        timing;
    logic        timeoutHit;

    assign timing = (state_q == ST_TIMING);

    // The prescaler only runs inside a window, so it is already zero when
    // the next window opens.
    tdc_tick_gen #(
        .DIV(CLK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!timing),
        .count_en_i(timing),
        .tick_o    (tick)
    );

`ifdef TDC_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_COUNT);
    assign timeoutHit = timing && (cnt_q == TIMEOUT_LIMIT);
`else
    assign timeoutHit = 1'b0;
`endif

    // State register; reset always lands in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear beats everything, then dropping enable, then hits.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = enable ? ST_ARMED : ST_IDLE;
        end else if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_ARMED;
                ST_ARMED:   if (start_hit) state_d = ST_TIMING;
                ST_TIMING:  if (stop_hit || timeoutHit) state_d = ST_HOLDOFF;
                ST_HOLDOFF: if (hold_q == HOLD_LAST) state_d = ST_ARMED;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next values: TDC count, holdoff counter, result and flags.
    // A stop wins over a timeout landing in the same cycle.
    always_comb begin
        cnt_d     = 16'd0;
        hold_d    = 16'd0;
        result_d  = result_q;
        events_d  = events_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        if (clear) begin
            result_d = 16'd0;
            events_d = 16'd0;
        end else if (enable) begin
            case (state_q)
                ST_TIMING: begin
                    if (stop_hit) begin
                        result_d = cnt_q;
                        events_d = satInc(events_q);
                        valid_d  = 1'b1;
                    end else if (timeoutHit) begin
                        timeout_d = 1'b1;
                    end else if (tick) begin
                        cnt_d = satInc(cnt_q);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_q != HOLD_LAST) begin
                        hold_d = hold_q + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers; reset zeroes every counter and flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 16'd0;
            hold_q    <= 16'd0;
            result_q  <= 16'd0;
            events_q  <= 16'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            result_q  <= result_d;
            events_q  <= events_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign result        = result_q;
    assign result_valid  = valid_q;
    assign event_count   = events_q;
    assign timeout_pulse = timeout_q;
    assign busy          = (state_q == ST_TIMING) || (state_q == ST_HOLDOFF);

endmodule

// File: doc/tdc_run_ctrl.md
TDC_RUN_CTRL -- requirements
Module: tdc_run_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 100: clk cycles per TDC count (1 us at 100 MHz); legal range 2..65535.
REQ-002 Parameter TIMEOUT_COUNT, default 20000: TDC count at which an open window is abandoned; legal range 1..65535.
REQ-003 Parameter HOLDOFF_CYCLES, default 1000: dead time in clk cycles after each window closes; legal range 1..65535.
REQ-004 clk  in  1  single 100 MHz system clock; every flop is clocked on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  run enable, driven from the TDC mode switch.
REQ-007 start_hit  in  1  one-cycle pulse: a muon stop event from the coincidence logic.
REQ-008 stop_hit  in  1  one-cycle pulse: a decay electron event from the coincidence logic.
REQ-009 clear  in  1  one-cycle pulse: zero the results and restart the run.
REQ-010 result  out  16  last measured interval, in TDC counts.
REQ-011 result_valid  out  1  one-cycle pulse when result updates.
REQ-012 event_count  out  16  number of completed measurements, saturating.
REQ-013 timeout_pulse  out  1  one-cycle pulse when a window is abandoned.
REQ-014 busy  out  1  high in TIMING and HOLDOFF.

Function
REQ-015 The FSM SHALL have the states IDLE, ARMED, TIMING and HOLDOFF.
REQ-016 IDLE->ARMED SHALL occur when enable=1; any state SHALL go to IDLE on the next edge when enable=0, and the open measurement is discarded with no result_valid.
REQ-017 ARMED->TIMING SHALL occur on start_hit; the prescaler and the TDC count are zeroed on entry.
REQ-018 In TIMING the prescaler SHALL increment every cycle, wrap at CLK_DIV-1, and increment the TDC count on each wrap.
REQ-019 Behaviour on stop_hit in TIMING:
- result SHALL take the current TDC count, so result = floor((d-1)/CLK_DIV), where d is the cycle distance from start_hit to stop_hit.
- result_valid SHALL pulse in the next cycle.
- event_count SHALL increment, saturating at 16'hFFFF.
- The state SHALL go to HOLDOFF.
REQ-020 HOLDOFF SHALL last exactly HOLDOFF_CYCLES cycles and then go to ARMED; start_hit and stop_hit are ignored in HOLDOFF.
REQ-021 stop_hit in ARMED or IDLE SHALL be ignored.
REQ-022 If start_hit and stop_hit arrive together in ARMED, start SHALL win and that stop SHALL be ignored.
REQ-023 A start_hit in TIMING SHALL be ignored, with no retrigger.
REQ-024 clear SHALL have the following effects:
- result and event_count are zeroed on the next edge.
- Any open window is discarded.
- The state goes to ARMED if enable=1, otherwise to IDLE.
- clear takes priority over start_hit and stop_hit in the same cycle.
REQ-025 result SHALL hold its value between updates; result_valid and timeout_pulse are never high together.

Reset
REQ-026 On rst=1 at a clock edge, the state SHALL be IDLE, and result, event_count, prescaler, TDC count and holdoff counter SHALL all be 0.
REQ-027 On rst=1 at a clock edge, result_valid, timeout_pulse and busy SHALL be 0.
REQ-028 rst SHALL dominate enable, clear and the hit inputs, including in mid-window and mid-holdoff.

Configuration
REQ-029 Behaviour with macro TDC_TIMEOUT_EN defined:
- When the TDC count reaches TIMEOUT_COUNT in TIMING, the FSM SHALL go to HOLDOFF.
- timeout_pulse SHALL pulse for one cycle.
- result and event_count SHALL stay unchanged.
- If stop_hit arrives in the same cycle as the timeout, the stop SHALL win.
REQ-030 Behaviour with TDC_TIMEOUT_EN not defined:
- The TDC count SHALL saturate at 16'hFFFF.
- TIMING SHALL persist until stop_hit, clear, enable=0 or rst.
- timeout_pulse SHALL be tied to 0.

Structure
REQ-031 Shared package muon_pkg SHALL hold the FSM state enum and the default constants for CLK_DIV, TIMEOUT_COUNT and HOLDOFF_CYCLES.
REQ-032 The prescaler SHALL be a sub-module tdc_tick_gen, with synchronous clear and a one-cycle tick output, instantiated once.

Verification
REQ-033 With CLK_DIV=4 and enable=1: start_hit at cycle 0 and stop_hit at cycle 10 -> result=2, result_valid high at cycle 11, event_count=1.
REQ-034 With CLK_DIV=4: start_hit and stop_hit together in ARMED, then stop_hit 21 cycles later -> exactly one result_valid, with result=5.
REQ-035 With TDC_TIMEOUT_EN defined, CLK_DIV=2 and TIMEOUT_COUNT=3: start_hit with no stop -> timeout_pulse once, result_valid never, event_count=0, then ARMED after HOLDOFF_CYCLES.
REQ-036 With HOLDOFF_CYCLES=5: stop_hit, then a new start_hit 3 cycles later -> ignored; a start_hit 6 cycles after the stop -> accepted.
REQ-037 enable dropped in mid-TIMING -> IDLE next cycle and no result_valid; clear together with stop_hit -> result=0 and event_count=0.
REQ-038 rst asserted in HOLDOFF with event_count=7 -> all outputs 0 and state IDLE on the next edge.
